modexp_engine: RTL and testbench
================================

Name: modexp_engine

Overview:
- Iterative modular-exponentiation unit computing result = base^exp mod mod using bit-serial interleaved modular multiplication and left-to-right square-and-multiply.
- Feeds one input of the operation-select result mux, which registers its output.
- Operands are captured on a start strobe. A one-cycle done pulse marks a valid result.
- Uses no divider and no "%" operator; all reduction is by conditional subtraction.

Parameters:
- WIDTH, 8, bit width of base, exp, mod and result.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  request; sampled only in IDLE.
- base  in  WIDTH  base operand, latched when start is accepted.
- exp  in  WIDTH  exponent, latched when start is accepted.
- mod  in  WIDTH  modulus, latched when start is accepted.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when result/err are updated.
- err  out  1  high when the last accepted request had mod==0; held until next done.
- result  out  WIDTH  last computed value; held until next done.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: state=IDLE; busy, done, err, result = 0; internal registers = 0. Reset mid-operation aborts the operation with no done pulse. Next start is accepted normally.
- Start acceptance: start is accepted only in IDLE. Base/exp/mod are latched on that edge. start is ignored in all other states, including the FINISH (done) cycle. Input changes after acceptance have no effect.
- mod==0: IDLE → FINISH directly. done=1 the next cycle, err=1, result=0.
- ONE = (mod==1) ? 0 : 1. Accumulator r is initialised to ONE.
- Modmul step, one cycle, for multiplier bit b processed MSB first:
  - acc' = 2*acc + (b ? x : 0), computed in WIDTH+2 bits.
  - Subtract mod while acc' >= mod; at most two subtractions, both in the same cycle.
  - Precondition acc, x < mod. Each modmul takes exactly WIDTH cycles with acc starting at 0.
- States:
  - IDLE: wait for start.
  - REDUCE: WIDTH cycles. Multiplier = base, multiplicand = ONE, giving xr = base mod mod.
  - SQR: WIDTH cycles. r = r*r mod mod (multiplier = r, multiplicand = r).
  - MUL: WIDTH cycles, entered only if the current exp bit = 1. r = r*xr mod mod.
  - NEXT: zero-time decision, folded into the last cycle of SQR/MUL. Decrement the bit index. After bit 0, go to FINISH; otherwise go to SQR.
  - FINISH: 1 cycle. result=r, err=0, done=1, then go to IDLE.
- Exponent bits are processed from bit WIDTH-1 down to bit 0. All bits are processed; leading zeros are squared.
- Latency: done is high in the cycle that begins WIDTH*(1+WIDTH+popcount(exp))+1 edges after the accepting edge.
  - WIDTH=8, exp=0: 73 cycles.
  - WIDTH=8, exp=0xFF: 137 cycles.
- Mathematical conventions: 0^0 = 1 mod m; any x mod 1 = 0.
- done and busy are both high in the FINISH cycle. busy drops the cycle after.

Optional Feature:
- Macro: MODEXP_SKIP_LZ_EN.
- Defined: after REDUCE, the bit index starts at the highest set bit of exp, so leading-zero SQR passes are skipped.
  - exp==0 goes REDUCE → FINISH.
  - Latency = WIDTH*(1+(msb_index+1)+popcount(exp))+1; exp==0 gives WIDTH+1.
  - Results are identical to the macro-undefined build.
- Undefined: fixed full-width iteration with the latency given under Behaviour.

Test Plan:
- base=3, exp=5, mod=7, start 1 cycle → busy=1 next cycle; done at cycle 89; result=5, err=0.
- base=7, exp=255, mod=13 → result=5 at cycle 137. base=0, exp=0, mod=7 → result=1 at cycle 73 (cycle 9 with MODEXP_SKIP_LZ_EN).
- mod=0, base=9, exp=2 → done the cycle after start, err=1, result=0. Follow with mod=1, base=200, exp=3 → result=0, err=0.
- Hold start high and toggle operands throughout a run of base=2, exp=10, mod=250 → exactly one done; result=24 (1024 mod 250). start is re-accepted only on the first cycle back in IDLE.
- Start base=5, exp=200, mod=23, then assert rst for 1 cycle at cycle 30 → busy=0, done never pulses, result=0. Then base=5, exp=3, mod=23 → result=10.
- Randomised sweep of 500 triples (mod≠0) against a reference model: result and per-run latency formula match for both macro settings.

Source files
------------

// File: rtl/modexp_engine_if.sv
// rtl/modexp_engine_if.sv - request/response bundle for the modular-exponentiation engine
interface modexp_engine_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] exp;
  logic [WIDTH-1:0] mod;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] result;

  modport master (output start, base, exp, mod, input busy, done, err, result);
  modport slave  (input start, base, exp, mod, output busy, done, err, result);
endinterface

// File: rtl/modexp_engine.sv
// rtl/modexp_engine.sv - base^exp mod mod via bit-serial modmul and left-to-right square-and-multiply
// Optional MODEXP_SKIP_LZ_EN starts iteration at the highest set exponent bit.
module modexp_engine #(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst,
  modexp_engine_if.slave bus
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, REDUCE, SQR, MUL, FINISH} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0] exp_q, mod_q, xr, r, acc, mplier, mcand, result_q;
  logic             err_q;
  logic [IW-1:0]    cnt, idx;
  logic [WIDTH+1:0] sum, s1, s2;
  logic [WIDTH-1:0] prod, new_r, one_in;
  logic             last, ebit, idx_zero;

  function automatic logic [IW-1:0] msb_of(input logic [WIDTH-1:0] v);
    msb_of = '0;
    for (int i = 0; i < WIDTH; i++)
      if (v[i]) msb_of = IW'(i);
  endfunction

  // One modmul step: acc < mod and mcand < mod keep the sum below 3*mod.
  always_comb begin
    sum = {1'b0, acc, 1'b0} + (mplier[WIDTH-1] ? {2'b00, mcand} : '0);
    s1  = (sum >= {2'b00, mod_q}) ? sum - {2'b00, mod_q} : sum;
    s2  = (s1 >= {2'b00, mod_q}) ? s1 - {2'b00, mod_q} : s1;
    prod     = s2[WIDTH-1:0];
    last     = (cnt == IW'(WIDTH - 1));
    ebit     = exp_q[idx];
    idx_zero = (idx == '0);
    new_r    = (state == REDUCE) ? r : prod;
    one_in   = (bus.mod == WIDTH'(1)) ? '0 : WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = (bus.mod == '0) ? FINISH : REDUCE;
      REDUCE:
        if (last) begin
`ifdef MODEXP_SKIP_LZ_EN
          state_nxt = (exp_q == '0) ? FINISH : SQR;
`else
          state_nxt = SQR;
`endif
        end
      SQR:
        if (last) begin
          if (ebit)          state_nxt = MUL;
          else if (idx_zero) state_nxt = FINISH;
          else               state_nxt = SQR;
        end
      MUL:     if (last) state_nxt = idx_zero ? FINISH : SQR;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy   = (state != IDLE);
    bus.done   = (state == FINISH);
    bus.err    = err_q;
    bus.result = result_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q    <= '0;
      mod_q    <= '0;
      xr       <= '0;
      r        <= '0;
      acc      <= '0;
      mplier   <= '0;
      mcand    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      cnt      <= '0;
      idx      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            exp_q  <= bus.exp;
            mod_q  <= bus.mod;
            acc    <= '0;
            cnt    <= '0;
            mplier <= bus.base;
            mcand  <= one_in;
            r      <= one_in;
`ifdef MODEXP_SKIP_LZ_EN
            idx    <= msb_of(bus.exp);
`else
            idx    <= IW'(WIDTH - 1);
`endif
            if (bus.mod == '0) begin
              result_q <= '0;
              err_q    <= 1'b1;
            end
          end
        end
        REDUCE, SQR, MUL: begin
          acc    <= prod;
          mplier <= mplier << 1;
          cnt    <= cnt + 1'b1;
          if (last) begin
            acc <= '0;
            cnt <= '0;
            if (state == REDUCE) xr <= prod;
            else                 r  <= prod;
            // Reload multiplier/multiplicand for whichever pass follows.
            case (state_nxt)
              SQR: begin
                mplier <= new_r;
                mcand  <= new_r;
              end
              MUL: begin
                mplier <= xr;
                mcand  <= new_r;
              end
              FINISH: begin
                result_q <= new_r;
                err_q    <= 1'b0;
              end
              default: ;
            endcase
            if (state != REDUCE && state_nxt == SQR) idx <= idx - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_modexp_engine.sv
// tb/tb_modexp_engine.sv - vector table, corner sequences and random sweep against an arithmetic model
module tb_modexp_engine;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  modexp_engine_if #(.WIDTH(W)) bus();
  modexp_engine #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int failed = 0;

  typedef struct {
    logic [7:0] b, e, m;
    logic [7:0] res;
    logic       er;
    int         lat;
  } vec_t;

`ifdef MODEXP_SKIP_LZ_EN
  localparam int L_3_5 = 49, L_7_255 = 137, L_0_0 = 9, L_200_3 = 41, L_5_3 = 41;
`else
  localparam int L_3_5 = 89, L_7_255 = 137, L_0_0 = 73, L_200_3 = 89, L_5_3 = 89;
`endif

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      failed++;
      $display("FAIL %s got=%0d expected=%0d", name, got, want);
    end
  endtask

  function automatic int ref_pow(input int b, input int e, input int m);
    int acc;
    acc = 1 % m;
    for (int i = 0; i < e; i++) acc = (acc * b) % m;
    return acc;
  endfunction

  function automatic int ref_lat(input int e, input int m);
    int pop, msb;
    if (m == 0) return 1;
    pop = 0;
    msb = -1;
    for (int i = 0; i < W; i++)
      if ((e >> i) & 1) begin
        pop++;
        msb = i;
      end
`ifdef MODEXP_SKIP_LZ_EN
    return W * (1 + (msb + 1) + pop) + 1;
`else
    return W * (1 + W + pop) + 1;
`endif
  endfunction

  // lat counts cycles from the accepting edge: the cycle right after it is 1.
  task automatic run_op(input logic [7:0] b, input logic [7:0] e, input logic [7:0] m,
                        output logic [7:0] res, output logic er, output int lat,
                        output logic first_busy);
    @(negedge clk);
    bus.base  = b;
    bus.exp   = e;
    bus.mod   = m;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.base  = 8'($urandom);
    bus.exp   = 8'($urandom);
    bus.mod   = 8'($urandom);
    lat = 1;
    @(negedge clk);
    first_busy = bus.busy;
    while (!bus.done && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.done) lat = -1;
    res = bus.result;
    er  = bus.err;
  endtask

  vec_t       vecs[6];
  logic [7:0] res;
  logic       er, fb;
  int         lat, dcount;
  logic [7:0] rb, re, rm;

  initial begin
    vecs[0] = '{8'd3,   8'd5,   8'd7,  8'd5,  1'b0, L_3_5};
    vecs[1] = '{8'd7,   8'd255, 8'd13, 8'd5,  1'b0, L_7_255};
    vecs[2] = '{8'd0,   8'd0,   8'd7,  8'd1,  1'b0, L_0_0};
    vecs[3] = '{8'd9,   8'd2,   8'd0,  8'd0,  1'b1, 1};
    vecs[4] = '{8'd200, 8'd3,   8'd1,  8'd0,  1'b0, L_200_3};
    vecs[5] = '{8'd5,   8'd3,   8'd23, 8'd10, 1'b0, L_5_3};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.base = '0;
    bus.exp = '0;
    bus.mod = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_err", bus.err, 0);
    check("reset_result", bus.result, 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].b, vecs[i].e, vecs[i].m, res, er, lat, fb);
      check($sformatf("vec%0d_result", i), res, vecs[i].res);
      check($sformatf("vec%0d_err", i), er, vecs[i].er);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_busy_after_start", i), fb, 1);
      @(negedge clk);
      check($sformatf("vec%0d_done_pulse", i), bus.done, 0);
      check($sformatf("vec%0d_busy_idle", i), bus.busy, 0);
    end

    // start held high with operands churning for the whole run
    @(negedge clk);
    bus.base = 8'd2;
    bus.exp = 8'd10;
    bus.mod = 8'd250;
    bus.start = 1'b1;
    @(posedge clk);
    lat = 1;
    dcount = 0;
    @(negedge clk);
    while (!bus.done && lat < 400) begin
      bus.base = 8'($urandom);
      bus.exp = 8'($urandom);
      bus.mod = 8'($urandom);
      @(negedge clk);
      lat++;
    end
    if (!bus.done) lat = -1;
    check("hold_result", bus.result, 24);
    check("hold_latency", lat, ref_lat(10, 250));
    bus.base = 8'd3;
    bus.exp = 8'd5;
    bus.mod = 8'd7;
    @(negedge clk);
    check("hold_idle_busy", bus.busy, 0);
    check("hold_idle_done", bus.done, 0);
    @(negedge clk);
    check("hold_reaccept_busy", bus.busy, 1);
    bus.start = 1'b0;
    lat = 0;
    while (!bus.done && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    check("hold_second_done_seen", bus.done, 1);
    check("hold_second_result", bus.result, 5);
    @(negedge clk);

    // reset in the middle of an operation
    bus.base = 8'd5;
    bus.exp = 8'd200;
    bus.mod = 8'd23;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (29) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midreset_busy", bus.busy, 0);
    check("midreset_result", bus.result, 0);
    dcount = 0;
    repeat (300) begin
      @(negedge clk);
      if (bus.done) dcount++;
    end
    check("midreset_no_done", dcount, 0);
    run_op(8'd5, 8'd3, 8'd23, res, er, lat, fb);
    check("post_reset_result", res, 10);
    check("post_reset_err", er, 0);

    for (int i = 0; i < 500; i++) begin
      rb = 8'($urandom_range(0, 255));
      re = 8'($urandom_range(0, 255));
      rm = 8'($urandom_range(1, 255));
      run_op(rb, re, rm, res, er, lat, fb);
      check($sformatf("rand%0d_result b=%0d e=%0d m=%0d", i, rb, re, rm), res, ref_pow(rb, re, rm));
      check($sformatf("rand%0d_latency e=%0d", i, re), lat, ref_lat(re, rm));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
